// File: rtl/ex_mem_stage_reg.sv
// rtl/ex_mem_stage_reg.sv - EX/MEM pipeline register with 2-entry skid buffer, flush and stall counter
module ex_mem_stage_reg #(
   parameter int DATA_W       = 32,
   parameter int REG_W        = 5,
   parameter int CTRL_W       = 9,
   parameter int REGWRITE_BIT = 0,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_rt_data,
   input  logic [DATA_W-1:0] in_br_tgt,
   input  logic              in_zero,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [REG_W-1:0]  in_dst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_alu,
   output logic [DATA_W-1:0] out_rt_data,
   output logic [DATA_W-1:0] out_br_tgt,
   output logic              out_zero,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [REG_W-1:0]  out_dst,
   output logic              fwd_valid,
   output logic [REG_W-1:0]  fwd_dst,
   output logic [DATA_W-1:0] fwd_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef struct packed {
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] rtData;
      logic [DATA_W-1:0] brTgt;
      logic              zero;
      logic [CTRL_W-1:0] ctrl;
      logic [REG_W-1:0]  dst;
   } EntryT;

   EntryT            mainEnt, skidEnt, inEnt;
   logic             mainValid, skidValid;
   logic             mainValidNext, skidValidNext;
   logic             loadMainIn, loadMainSkid, loadSkid;
   logic             inFire, outFire;
   logic [CNT_W-1:0] stallCnt;

   assign inEnt   = '{alu: in_alu, rtData: in_rt_data, brTgt: in_br_tgt,
                      zero: in_zero, ctrl: in_ctrl, dst: in_dst};
   assign inFire  = in_valid & ~skidValid;
   assign outFire = mainValid & out_ready;

   // State register: the two valid bits are the FSM state (EMPTY/ONE/TWO).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mainValid <= 1'b0;
         skidValid <= 1'b0;
         mainEnt   <= '0;
         skidEnt   <= '0;
      end else begin
         mainValid <= mainValidNext;
         skidValid <= skidValidNext;
         if (loadMainIn)
            mainEnt <= inEnt;
         else if (loadMainSkid)
            mainEnt <= skidEnt;
         if (loadSkid)
            skidEnt <= inEnt;
      end
   end

   // Next-state: flush wins over any fire; a concurrent output fire is still delivered.
   always_comb begin
      mainValidNext = mainValid;
      skidValidNext = skidValid;
      loadMainIn    = 1'b0;
      loadMainSkid  = 1'b0;
      loadSkid      = 1'b0;
      if (flush) begin
         mainValidNext = 1'b0;
         skidValidNext = 1'b0;
      end else begin
         case ({skidValid, mainValid})
            2'b00: begin
               if (inFire) begin
                  loadMainIn    = 1'b1;
                  mainValidNext = 1'b1;
               end
            end
            2'b01: begin
               if (inFire && outFire) begin
                  loadMainIn = 1'b1;
               end else if (inFire) begin
                  loadSkid      = 1'b1;
                  skidValidNext = 1'b1;
               end else if (outFire) begin
                  mainValidNext = 1'b0;
               end
            end
            2'b11: begin
               if (outFire) begin
                  loadMainSkid  = 1'b1;
                  skidValidNext = 1'b0;
               end
            end
            default: begin
               mainValidNext = 1'b0;
               skidValidNext = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stallCnt <= '0;
      else if (mainValid && !out_ready && stallCnt != {CNT_W{1'b1}})
         stallCnt <= stallCnt + 1'b1;
   end

   // Outputs: only the control bundle is bubble-gated; data fields keep their last value.
   always_comb begin
      in_ready    = ~skidValid;
      out_valid   = mainValid;
      out_alu     = mainEnt.alu;
      out_rt_data = mainEnt.rtData;
      out_br_tgt  = mainEnt.brTgt;
      out_zero    = mainEnt.zero;
      out_dst     = mainEnt.dst;
      out_ctrl    = mainValid ? mainEnt.ctrl : '0;
      fwd_valid   = mainValid & mainEnt.ctrl[REGWRITE_BIT];
      fwd_dst     = mainEnt.dst;
      fwd_data    = mainEnt.alu;
      stall_cnt   = stallCnt;
   end

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// tb/tb_ex_mem_stage_reg.sv - directed self-checking bench for ex_mem_stage_reg
module tb_ex_mem_stage_reg;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, in_zero;
   logic [31:0] in_alu, in_rt_data, in_br_tgt;
   logic [8:0]  in_ctrl;
   logic [4:0]  in_dst;
   logic        out_valid, out_ready, out_zero, fwd_valid;
   logic [31:0] out_alu, out_rt_data, out_br_tgt, fwd_data;
   logic [8:0]  out_ctrl;
   logic [4:0]  out_dst, fwd_dst;
   logic [3:0]  stall_cnt;

   int nChecks = 0;
   int nPass   = 0;

   always #5 clk = ~clk;

   ex_mem_stage_reg #(.CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu(in_alu), .in_rt_data(in_rt_data), .in_br_tgt(in_br_tgt),
      .in_zero(in_zero), .in_ctrl(in_ctrl), .in_dst(in_dst),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_alu(out_alu), .out_rt_data(out_rt_data), .out_br_tgt(out_br_tgt),
      .out_zero(out_zero), .out_ctrl(out_ctrl), .out_dst(out_dst),
      .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
      .stall_cnt(stall_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      if (obs === exp)
         nPass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] alu, input logic [8:0] ctrl);
      in_valid   = 1'b1;
      in_alu     = alu;
      in_rt_data = alu ^ 32'hFFFF_0000;
      in_br_tgt  = alu + 32'h100;
      in_ctrl    = ctrl;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_alu = '0; in_rt_data = '0; in_br_tgt = '0; in_zero = 1'b0;
      in_ctrl = '0; in_dst = '0;

      // Reset with inputs toggling
      for (int i = 0; i < 4; i++) begin
         beat(32'h55 + 32'(i), 9'h1FF);
         in_valid  = i[0];
         out_ready = i[1];
         tick();
      end
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_ctrl", 64'(out_ctrl), 64'h0);
      chk("rst_in_ready", 64'(in_ready), 64'h1);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
      chk("rst_out_alu", 64'(out_alu), 64'h0);

      rst_n = 1'b1;
      out_ready = 1'b1;
      beat(32'h0000_1234, 9'h002);
      tick();
      chk("first_out_alu", 64'(out_alu), 64'h1234);
      chk("first_out_valid", 64'(out_valid), 64'h1);
      in_valid = 1'b0;
      tick();
      chk("drain_out_valid", 64'(out_valid), 64'h0);
      chk("bubble_ctrl", 64'(out_ctrl), 64'h0);

      // Streaming
      for (int i = 1; i <= 10; i++) begin
         beat(32'(i), 9'h004);
         chk("stream_in_ready", 64'(in_ready), 64'h1);
         tick();
         chk("stream_out_alu", 64'(out_alu), 64'(i));
         chk("stream_out_valid", 64'(out_valid), 64'h1);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_stall_cnt", 64'(stall_cnt), 64'h0);

      // Stall and skid
      out_ready = 1'b0;
      beat(32'hA, 9'h010);
      tick();
      chk("stall_a_alu", 64'(out_alu), 64'hA);
      beat(32'hB, 9'h010);
      tick();
      chk("stall_cnt1", 64'(stall_cnt), 64'h1);
      chk("stall_in_ready_lo", 64'(in_ready), 64'h0);
      beat(32'hC, 9'h010);
      tick();
      chk("stall_cnt2", 64'(stall_cnt), 64'h2);
      chk("stall_hold_a", 64'(out_alu), 64'hA);
      tick();
      chk("stall_cnt3", 64'(stall_cnt), 64'h3);
      chk("stall_out_a", 64'(out_alu), 64'hA);
      out_ready = 1'b1;
      tick();
      chk("skid_out_b", 64'(out_alu), 64'hB);
      chk("skid_b_rt", 64'(out_rt_data), 64'hFFFF_000B);
      chk("skid_in_ready_hi", 64'(in_ready), 64'h1);
      tick();
      chk("skid_out_c", 64'(out_alu), 64'hC);
      chk("skid_c_tgt", 64'(out_br_tgt), 64'h10C);
      in_valid = 1'b0;
      tick();
      chk("skid_empty", 64'(out_valid), 64'h0);
      chk("skid_cnt_held", 64'(stall_cnt), 64'h3);

      // Flush in TWO state
      out_ready = 1'b0;
      beat(32'h11, 9'h1FF);
      tick();
      beat(32'h22, 9'h1FF);
      tick();
      chk("pre_flush_in_ready", 64'(in_ready), 64'h0);
      beat(32'h33, 9'h1FF);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 64'(out_valid), 64'h0);
      chk("flush_out_ctrl", 64'(out_ctrl), 64'h0);
      chk("flush_in_ready", 64'(in_ready), 64'h1);
      chk("flush_cnt_kept", 64'(stall_cnt), 64'h5);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("flush_no_leak", 64'(out_valid), 64'h0);
      end

      // Forwarding
      beat(32'hDEAD_BEEF, 9'h001);
      in_dst  = 5'd7;
      in_zero = 1'b1;
      tick();
      chk("fwd_valid_on", 64'(fwd_valid), 64'h1);
      chk("fwd_dst", 64'(fwd_dst), 64'h7);
      chk("fwd_data", 64'(fwd_data), 64'hDEAD_BEEF);
      chk("fwd_out_zero", 64'(out_zero), 64'h1);
      chk("fwd_out_ctrl", 64'(out_ctrl), 64'h001);
      beat(32'hDEAD_BEEF, 9'h0FE);
      tick();
      chk("fwd_valid_off", 64'(fwd_valid), 64'h0);
      chk("fwd_ctrl_pass", 64'(out_ctrl), 64'h0FE);
      in_valid = 1'b0;
      tick();
      chk("bubble_ctrl_zero", 64'(out_ctrl), 64'h0);
      chk("bubble_alu_kept", 64'(out_alu), 64'hDEAD_BEEF);
      chk("bubble_dst_kept", 64'(out_dst), 64'h7);

      // Saturation and async reset mid-stall
      out_ready = 1'b0;
      beat(32'h77, 9'h001);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("sat_cnt", 64'(stall_cnt), 64'hF);
      chk("sat_still_valid", 64'(out_valid), 64'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_cnt", 64'(stall_cnt), 64'h0);
      chk("async_rst_valid", 64'(out_valid), 64'h0);
      chk("async_rst_in_ready", 64'(in_ready), 64'h1);
      chk("async_rst_fwd", 64'(fwd_valid), 64'h0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage_reg.md
Name: ex_mem_stage_reg

Overview:
- Parametrised EX/MEM pipeline stage register. Replaces the plain clocked latch between execute and memory.
- Adds a valid/ready handshake with a 2-entry skid buffer, so a memory-side stall never loses an EX result.
- Adds a synchronous flush that inserts bubbles, bubble-gated control outputs, a forwarding tap and a saturating stall counter.
- Sits between the ALU/branch-adder outputs and the data-memory / MEM-WB stage.

Parameters:
- DATA_W, 32, width of the ALU result, rt store data and branch target.
- REG_W, 5, width of the destination register index.
- CTRL_W, 9, width of the packed control bundle: RegWrite, MemRead, MemWrite, Branch, MemtoReg[1:0], load/store size flags.
- REGWRITE_BIT, 0, index of RegWrite inside the control bundle.
- CNT_W, 16, width of the stall counter.

Ports:
- clk, in, 1, clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- flush, in, 1, synchronous kill of all held and incoming entries.
- in_valid, in, 1, EX has a beat.
- in_ready, out, 1, stage can accept a beat.
- in_alu, in, DATA_W, ALU result.
- in_rt_data, in, DATA_W, store data (rt).
- in_br_tgt, in, DATA_W, branch target from the EX adder.
- in_zero, in, 1, ALU zero flag.
- in_ctrl, in, CTRL_W, control bundle.
- in_dst, in, REG_W, destination register (output of the rt/rd mux).
- out_valid, out, 1, MEM side has a beat.
- out_ready, in, 1, MEM side accepts the beat.
- out_alu, out_rt_data, out_br_tgt, out, DATA_W each, registered fields.
- out_zero, out, 1, registered zero flag.
- out_ctrl, out, CTRL_W, registered control bundle, gated by out_valid.
- out_dst, out, REG_W, registered destination register.
- fwd_valid, out, 1, equals out_valid AND out_ctrl[REGWRITE_BIT].
- fwd_dst, out, REG_W, equals out_dst.
- fwd_data, out, DATA_W, equals out_alu.
- stall_cnt, out, CNT_W, count of stalled cycles.

Behaviour:
- Storage is one main entry (drives the out_* ports) and one skid entry. Each entry is a full field bundle plus a valid bit.
- State is derived from the two valid bits: EMPTY (no entries), ONE (main valid), TWO (main and skid valid).
- in_ready = NOT skid_valid. It comes straight from a register, with no combinational path from out_ready.
- Handshake rules:
  - An input fire is in_valid AND in_ready.
  - An output fire is out_valid AND out_ready.
  - out_valid = main_valid.
  - Producers must hold their data stable while valid is high and ready is low.
- Latency: one clock from input fire to out_valid when the stage is EMPTY, or in ONE with a simultaneous output fire.
- Transitions, applied at the clock edge when flush = 0:
  - EMPTY, input fire: the beat goes to main; next state ONE.
  - ONE, input fire and output fire: new beat replaces main; state stays ONE.
  - ONE, input fire only: the beat goes to skid; next state TWO.
  - ONE, output fire only: next state EMPTY.
  - TWO, output fire: skid moves to main; next state ONE. No input can fire because in_ready = 0.
  - No fire in any state: hold.
- Ordering is strict FIFO. The skid entry is never presented before main.
- Flush is synchronous and overrides every other event:
  - Both valid bits clear at the next edge and the next state is EMPTY.
  - A beat that fires on the input in the same cycle is discarded.
  - An output fire in the flush cycle still counts as delivered.
- Bubble gating: out_ctrl = 0 whenever out_valid = 0, so RegWrite, MemRead, MemWrite and Branch can never assert on a bubble.
- Only out_ctrl is gated. out_alu, out_rt_data, out_br_tgt, out_zero and out_dst keep their last loaded values while invalid.
- stall_cnt:
  - Increments by 1 on every cycle with out_valid = 1 and out_ready = 0.
  - Saturates at 2^CNT_W - 1 and does not wrap.
  - Is not cleared by flush.
- Reset, with rst_n low and asynchronous:
  - main_valid and skid_valid go to 0, so in_ready reads 1.
  - All data and control registers go to 0.
  - stall_cnt goes to 0.
  - All outputs read 0 except in_ready.
  - Asserting reset in the middle of a stall drops both entries immediately.
  - The first edge after rst_n rises behaves as EMPTY.
- Fields are not widened or truncated. Every field passes bit-exact.

Test Plan:
- Reset: hold rst_n = 0 with the inputs toggling → out_valid = 0, out_ctrl = 0, in_ready = 1, stall_cnt = 0. Release rst_n and drive one beat with in_alu = 0x0000_1234 → out_alu = 0x0000_1234 and out_valid = 1 on the next edge.
- Streaming: out_ready = 1, ten back-to-back beats with in_alu = 1..10 → out_alu = 1..10 in order, each one cycle after its input. in_ready stays 1 throughout and stall_cnt stays 0.
- Stall and skid: with out_ready = 0, send beats A = 0xA and B = 0xB, then hold in_valid with C = 0xC. in_ready drops after B; out_alu stays 0xA; stall_cnt counts 1, 2, 3. Raise out_ready → outputs A, B, C in order; C is accepted only after the skid entry frees.
- Flush in TWO state: entries A and B are held and in_valid carries C when flush = 1 → next cycle out_valid = 0, out_ctrl = 0, in_ready = 1. A, B and C never appear at the output.
- Forwarding: a beat with in_ctrl[REGWRITE_BIT] = 1, in_dst = 5'd7, in_alu = 0xDEAD_BEEF → fwd_valid = 1, fwd_dst = 7, fwd_data = 0xDEAD_BEEF. The same beat with RegWrite = 0 gives fwd_valid = 0.
- Saturation: with CNT_W = 4, hold out_valid = 1 and out_ready = 0 for 20 cycles → stall_cnt stops at 15. Async reset applied mid-stall → stall_cnt and out_valid read 0 immediately, without waiting for a clock edge.
